// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and counter-width helper for the serial arithmetic blocks
//   exports: state_t {IDLE, SHIFT, DONE}, cnt_width(w) -> bits needed to count 0..w
package serial_arith_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor, d = a - b - bin
//   inputs  a, b, bin : minuend bit, subtrahend bit, borrow-in
//   outputs d, bout   : difference bit, borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock
//   clk, rst (async, active-high), start : control inputs
//   a, b, bin : operands, latched on an accepted start (IDLE or DONE)
//   busy : high during the WIDTH SHIFT cycles; done : one-cycle result strobe
//   diff, bout : registered result and final borrow, held until the next result lands
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res_sr, res_nxt;
    logic [CW-1:0]    cnt;
    logic             brw, brw_nxt, d, accept, last;

    assign accept = start && state != SHIFT;
    assign last   = state == SHIFT && cnt == CW'(WIDTH - 1);
    // New bit enters at the MSB so that after WIDTH shifts bit i sits at position i.
    assign res_nxt = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));

    full_subtractor u_fs (
        .a   (a_r[0]),
        .b   (b_r[0]),
        .bin (brw),
        .d   (d),
        .bout(brw_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = accept ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    end

    always_comb begin
        busy = state == SHIFT;
        done = state == DONE;
    end

    // res_sr is a scratch accumulator; diff/bout only update on the final bit,
    // so the previous result stays visible while the next one is being built.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            res_sr <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            brw <= bin;
            cnt <= '0;
        end else if (state == SHIFT) begin
            a_r    <= a_r >> 1;
            b_r    <= b_r >> 1;
            brw    <= brw_nxt;
            cnt    <= cnt + 1'b1;
            res_sr <= res_nxt;
            if (last) begin
                diff <= res_nxt;
                bout <= brw_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic busy1, done1, diff1, bout1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    function automatic logic [8:0] model(input logic [7:0] ia, ib, input logic ibin);
        int r;
        r = int'(ia) - int'(ib) - int'(ibin);
        return {r < 0, 8'(r)};
    endfunction

    // Drives one start pulse, then samples each falling edge until done (bounded).
    task automatic op8(input logic [7:0] ia, ib, input logic ibin,
                       output int lat, output int nbusy, output logic [7:0] od, output logic ob);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        start = 1'b0; lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            nbusy += int'(busy);
            @(negedge clk);
            lat++;
        end
        od = diff; ob = bout;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            errors++; $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
        end
        checks++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            errors++; $display("FAIL reset1: got %b, want 0000", {busy1, done1, diff1, bout1});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, nb; logic [7:0] od; logic ob;
        op8(8'd100, 8'd37, 1'b0, lat, nb, od, ob);
        checks++;
        if (lat !== 9 || nb !== 8) begin
            errors++; $display("FAIL basic_latency: got lat=%0d busy=%0d, want 9/8", lat, nb);
        end
        checks++;
        if (od !== 8'd63 || ob !== 1'b0) begin
            errors++; $display("FAIL basic_result: got %0d/%b, want 63/0", od, ob);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_borrow;
        int lat, nb; logic [7:0] od; logic ob;
        op8(8'd5, 8'd9, 1'b0, lat, nb, od, ob);
        checks++;
        if (od !== 8'hFC || ob !== 1'b1) begin
            errors++; $display("FAIL borrow_5_9: got %h/%b, want fc/1", od, ob);
        end
        op8(8'd0, 8'd0, 1'b1, lat, nb, od, ob);
        checks++;
        if (od !== 8'hFF || ob !== 1'b1) begin
            errors++; $display("FAIL borrow_bin: got %h/%b, want ff/1", od, ob);
        end
    endtask

    task automatic test_random;
        int lat, nb; logic [7:0] od, ra, rb; logic ob, rbin; logic [8:0] e;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            e = model(ra, rb, rbin);
            op8(ra, rb, rbin, lat, nb, od, ob);
            checks++;
            if ({ob, od} !== e || lat !== 9) begin
                errors++; $display("FAIL random %0d-%0d-%0d: got %b/%h lat=%0d, want %b/%h lat=9", ra, rb, rbin, ob, od, lat, e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_start_held;
        logic [8:0] e; int nb, nd;
        e = model(8'd150, 8'd45, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 8'd150; b = 8'd45; bin = 1'b1;
        nb = 0; nd = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            nb += int'(busy); nd += int'(done);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (i == 8) start = 1'b0;
        end
        checks++;
        if (nb !== 8 || nd !== 0) begin
            errors++; $display("FAIL held_busy: got busy=%0d done=%0d, want 8/0", nb, nd);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || {bout, diff} !== e) begin
            errors++; $display("FAIL held_result: got done=%b %b/%h, want 1 %b/%h", done, bout, diff, e[8], e[7:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL held_single_done: got done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nb; logic [7:0] od; logic ob;
        op8(8'd30, 8'd10, 1'b0, lat, nb, od, ob);
        start = 1'b1; a = 8'd200; b = 8'd100; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'd20) begin
            errors++; $display("FAIL b2b_no_idle: got busy=%b done=%b diff=%0d, want 1/0/20", busy, done, diff);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || diff !== 8'd100 || bout !== 1'b0) begin
            errors++; $display("FAIL b2b_result: got lat=%0d %0d/%b, want 9 100/0", lat, diff, bout);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nb, nd; logic [7:0] od; logic ob;
        op8(8'd77, 8'd11, 1'b0, lat, nb, od, ob);
        @(negedge clk);
        start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            nd += int'(done);
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d done pulses, want 0", nd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b1; a = 8'd50; b = 8'd20; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_after_reset: got busy=%b, want 1", busy);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || diff !== 8'd30 || bout !== 1'b0) begin
            errors++; $display("FAIL fresh_after_reset: got lat=%0d %0d/%b, want 9 30/0", lat, diff, bout);
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            s1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
            @(negedge clk);
            s1 = 1'b0;
            @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || {diff1, bout1} !== exp1[i]) begin
                errors++; $display("FAIL w1 abc=%b: got done=%b %b%b, want 1 %b", v, done1, diff1, bout1, exp1[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_random;
        test_start_held;
        test_back_to_back;
        test_reset_mid;
        test_width1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
